// File: rtl/fifo_wr_arbiter_if.sv
// Requester streams plus FIFO write-port bundle for fifo_wr_arbiter.
// master: the arbiter side (drives ready, FIFO write, grant status).
// slave : requesters and FIFO side (drives valid/data and FIFO flags).
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 128
);
  localparam int unsigned GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;   // requester i at bits [i*DATA_W +: DATA_W]
  logic [NUM_REQ-1:0]             req_ready;
  logic                           o_full;
  logic                           o_alm_full;
  logic                           i_wren;
  logic [DATA_W-1:0]              i_wrdata;
  logic [GID_W-1:0]               grant_id;
  logic                           busy;

  modport master (
    input  req_valid, req_data, o_full, o_alm_full,
    output req_ready, i_wren, i_wrdata, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, o_full, o_alm_full,
    input  req_ready, i_wren, i_wrdata, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready
// requesters. A grant lasts up to MAX_BURST beats; the FIFO write is issued
// one register stage after acceptance. Acceptance is blocked whenever the FIFO
// reports full or almost-full, and the almost-full margin covers the single
// write in flight.
// Optional build macro FIFO_ARB_STATS_EN adds per-requester saturating beat
// counters (stat_beats) with a synchronous clear (stat_clr).
// Note: rstn is an active-high asynchronous reset despite its name.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
`ifdef FIFO_ARB_STATS_EN
  input  logic                    stat_clr,
  output logic [NUM_REQ-1:0][31:0] stat_beats,
`endif
  fifo_wr_arbiter_if.master       bus
);

  localparam int unsigned GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t            state;
  logic [BC_W-1:0]   beat_cnt;

  logic              stall;
  logic              sel_valid;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic              pick_found;
  logic [GID_W-1:0]  pick_idx;
  int unsigned       cand;

  // Flag decode and the granted requester's view of the handshake.
  always_comb begin
    stall     = bus.o_full | bus.o_alm_full;
    sel_valid = bus.req_valid[bus.grant_id];
    sel_data  = bus.req_data[bus.grant_id];
    accept    = (state == ST_BURST) & sel_valid & ~stall;
  end

  // Ready only toward the granted requester while bursting and not throttled.
  always_comb begin
    bus.req_ready = '0;
    if ((state == ST_BURST) && !stall) begin
      bus.req_ready[bus.grant_id] = 1'b1;
    end
  end

  // Round-robin pick: first valid index after the last grant, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(bus.grant_id) + k) % NUM_REQ;
      if (!pick_found && bus.req_valid[GID_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = GID_W'(cand);
      end
    end
  end

  // Arbitration FSM with registered FIFO write stage and status outputs.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      bus.grant_id <= GID_W'(NUM_REQ - 1);
      bus.busy     <= 1'b0;
      bus.i_wren   <= 1'b0;
      bus.i_wrdata <= '0;
    end else begin
      bus.i_wren <= accept;
      if (accept) begin
        bus.i_wrdata <= sel_data;
      end

      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            bus.grant_id <= pick_idx;
            beat_cnt     <= '0;
            state        <= ST_BURST;
            bus.busy     <= 1'b1;
          end
        end

        ST_BURST: begin
          // A dropped valid releases the grant even while stalled.
          if (!sel_valid) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end else if (accept) begin
            if (beat_cnt == LAST_BEAT) begin
              state    <= ST_IDLE;
              bus.busy <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + BC_W'(1);
            end
          end
        end

        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  // Saturating per-requester accepted-beat counters; clear beats a coincident accept.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      stat_beats <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (stat_clr) begin
          stat_beats[i] <= '0;
        end else if (accept && (bus.grant_id == GID_W'(i)) &&
                     (stat_beats[i] != 32'hFFFF_FFFF)) begin
          stat_beats[i] <= stat_beats[i] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4).
// Stats checks are compiled in when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned DATA_W    = 128;
  localparam int unsigned MAX_BURST = 4;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;
  int   cnt [NUM_REQ];

`ifdef FIFO_ARB_STATS_EN
  logic                      stat_clr;
  logic [NUM_REQ-1:0][31:0]  stat_beats;
`endif

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
`ifdef FIFO_ARB_STATS_EN
    .stat_clr  (stat_clr),
    .stat_beats(stat_beats),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tagged beat payload: requester id in the top word, beat number in the bottom.
  function automatic logic [127:0] mk(int i, int c);
    return {32'hDA7A_0000 + 32'(i), 64'h0, 32'(c)};
  endfunction

  task automatic chk_eq(string tag, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Restart every requester's beat numbering at 0.
  task automatic reset_cnts();
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i]          = 0;
      bus.req_data[i] = mk(i, 0);
    end
  endtask

  // One clock: requesters advance on accepted beats; a write must never
  // follow an edge at which the FIFO was full.
  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    logic               full_at_edge;
    #1;
    acc          = bus.req_valid & bus.req_ready;
    full_at_edge = bus.o_full;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        cnt[i]++;
        bus.req_data[i] = mk(i, cnt[i]);
      end
    end
    if (bus.i_wren) chk_eq("wren_into_full", 128'(full_at_edge), 128'(0));
  endtask

  initial begin
    int g;
    logic exp_wren;
    int ec [NUM_REQ];
    n_checks = 0;
    n_errors = 0;
    rstn           = 1'b1;
    bus.req_valid  = '0;
    bus.o_full     = 1'b0;
    bus.o_alm_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    reset_cnts();

    // Reset state
    repeat (2) tick();
    chk_eq("rst_wren",   128'(bus.i_wren),    128'(0));
    chk_eq("rst_wrdata", bus.i_wrdata,        128'(0));
    chk_eq("rst_ready",  128'(bus.req_ready), 128'(0));
    chk_eq("rst_grant",  128'(bus.grant_id),  128'(3));
    chk_eq("rst_busy",   128'(bus.busy),      128'(0));
    rstn = 1'b0;

    // Single requester 1: pattern 0 then (1,1,1,1,0) with in-order data
    reset_cnts();
    bus.req_valid = 4'b0010;
    g = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp_wren = ((e % 5) != 1);
      chk_eq("single_wren",  128'(bus.i_wren),   128'(exp_wren));
      chk_eq("single_grant", 128'(bus.grant_id), 128'(1));
      if (exp_wren) begin
        chk_eq("single_data", bus.i_wrdata, mk(1, g));
        g++;
      end
    end
    bus.req_valid = '0;
    tick();
    chk_eq("single_tail_wren", 128'(bus.i_wren), 128'(0));

    // Reset in the middle of a req0 burst
    reset_cnts();
    bus.req_valid = 4'b0001;
    tick();
    chk_eq("mid_grant0", 128'(bus.grant_id), 128'(0));
    tick();
    tick();
    chk_eq("mid_wren_pre", 128'(bus.i_wren), 128'(1));
    rstn = 1'b1;
    #1;
    chk_eq("mid_rst_wren",  128'(bus.i_wren),    128'(0));
    chk_eq("mid_rst_ready", 128'(bus.req_ready), 128'(0));
    chk_eq("mid_rst_grant", 128'(bus.grant_id),  128'(3));
    bus.req_valid = '0;
    tick();
    rstn = 1'b0;

    // All four valid: grants 0,1,2,3,0 of 4 beats each with one idle cycle
    reset_cnts();
    for (int i = 0; i < NUM_REQ; i++) ec[i] = 0;
    bus.req_valid = 4'b1111;
    for (int e = 1; e <= 25; e++) begin
      tick();
      g = ((e - 1) / 5) % 4;
      exp_wren = ((e % 5) != 1);
      chk_eq("rr_grant", 128'(bus.grant_id), 128'(g));
      chk_eq("rr_wren",  128'(bus.i_wren),   128'(exp_wren));
      chk_eq("rr_busy",  128'(bus.busy),     128'((e % 5) != 0));
      if (exp_wren) begin
        chk_eq("rr_data", bus.i_wrdata, mk(g, ec[g]));
        ec[g]++;
      end
    end
    bus.req_valid = '0;
    tick();

    // Almost-full stall for 5 cycles during req2's second beat
    reset_cnts();
    bus.req_valid = 4'b0100;
    tick();
    chk_eq("stall_grant", 128'(bus.grant_id), 128'(2));
    chk_eq("stall_arb_wren", 128'(bus.i_wren), 128'(0));
    tick();
    chk_eq("stall_b0_wren", 128'(bus.i_wren), 128'(1));
    chk_eq("stall_b0_data", bus.i_wrdata, mk(2, 0));
    bus.o_alm_full = 1'b1;
    #1;
    chk_eq("stall_ready_off", 128'(bus.req_ready), 128'(0));
    repeat (5) begin
      tick();
      chk_eq("stall_wren",  128'(bus.i_wren),    128'(0));
      chk_eq("stall_ready", 128'(bus.req_ready), 128'(0));
      chk_eq("stall_busy",  128'(bus.busy),      128'(1));
    end
    bus.o_alm_full = 1'b0;
    #1;
    chk_eq("stall_ready_on", 128'(bus.req_ready), 128'(4'b0100));
    for (int b = 1; b <= 3; b++) begin
      tick();
      chk_eq("stall_wren_post", 128'(bus.i_wren), 128'(1));
      chk_eq("stall_data_post", bus.i_wrdata, mk(2, b));
    end
    bus.req_valid = '0;
    chk_eq("stall_burst_end", 128'(bus.busy), 128'(0));
    tick();
    chk_eq("stall_tail_wren", 128'(bus.i_wren), 128'(0));
    chk_eq("stall_beats", 128'(cnt[2]), 128'(4));

    // Early release by req3 while req0 waits; req3 drops to lowest priority
    reset_cnts();
    bus.req_valid = 4'b1001;
    tick();
    chk_eq("rel_grant3", 128'(bus.grant_id), 128'(3));
    tick();
    chk_eq("rel_d0", bus.i_wrdata, mk(3, 0));
    tick();
    chk_eq("rel_d1", bus.i_wrdata, mk(3, 1));
    bus.req_valid[3] = 1'b0;
    tick();
    chk_eq("rel_wren", 128'(bus.i_wren), 128'(0));
    chk_eq("rel_busy", 128'(bus.busy),   128'(0));
    chk_eq("rel_keep", 128'(bus.grant_id), 128'(3));
    bus.req_valid[3] = 1'b1;
    tick();
    chk_eq("rel_grant0", 128'(bus.grant_id), 128'(0));
    for (int b = 0; b < 4; b++) begin
      tick();
      chk_eq("rel_r0_wren", 128'(bus.i_wren), 128'(1));
      chk_eq("rel_r0_data", bus.i_wrdata, mk(0, b));
    end
    tick();
    chk_eq("rel_regrant3", 128'(bus.grant_id), 128'(3));
    // Valid drop and full in the same cycle: the drop releases the grant
    bus.req_valid[3] = 1'b0;
    bus.o_full = 1'b1;
    #1;
    chk_eq("drop_full_ready", 128'(bus.req_ready), 128'(0));
    tick();
    chk_eq("drop_full_busy", 128'(bus.busy),   128'(0));
    chk_eq("drop_full_wren", 128'(bus.i_wren), 128'(0));
    tick();
    chk_eq("full_grant0", 128'(bus.grant_id), 128'(0));
    chk_eq("full_ready",  128'(bus.req_ready), 128'(0));
    tick();
    chk_eq("full_wren", 128'(bus.i_wren), 128'(0));
    chk_eq("full_busy", 128'(bus.busy),   128'(1));
    bus.o_full = 1'b0;
    bus.req_valid = '0;
    tick();
    chk_eq("full_release", 128'(bus.busy), 128'(0));

`ifdef FIFO_ARB_STATS_EN
    // Beat statistics: 10 beats from req0, 3 from req2, then clear
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk_eq("stat_pre_clr", 128'(stat_beats), 128'(0));
    reset_cnts();
    bus.req_valid = 4'b0001;
    for (int t = 0; t < 40 && bus.req_valid[0]; t++) begin
      tick();
      if (cnt[0] == 10) bus.req_valid[0] = 1'b0;
    end
    chk_eq("stat_r0_done", 128'(cnt[0]), 128'(10));
    bus.req_valid = '0;
    repeat (2) tick();
    bus.req_valid = 4'b0100;
    for (int t = 0; t < 40 && bus.req_valid[2]; t++) begin
      tick();
      if (cnt[2] == 3) bus.req_valid[2] = 1'b0;
    end
    chk_eq("stat_r2_done", 128'(cnt[2]), 128'(3));
    bus.req_valid = '0;
    repeat (2) tick();
    chk_eq("stat0", 128'(stat_beats[0]), 128'(10));
    chk_eq("stat1", 128'(stat_beats[1]), 128'(0));
    chk_eq("stat2", 128'(stat_beats[2]), 128'(3));
    chk_eq("stat3", 128'(stat_beats[3]), 128'(0));
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk_eq("stat_clr", 128'(stat_beats), 128'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares the 128-bit FIFO write port among NUM_REQ requesters. Each requester has a valid/ready stream interface. The block grants one requester at a time for a bounded burst and drives the FIFO i_wren/i_wrdata through one register stage. It throttles on the FIFO full and almost-full flags so that no write is ever lost or issued into a full FIFO.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 128, data width; matches FIFO i_wrdata
MAX_BURST, 4, maximum beats per grant before forced re-arbitration (1..16)

Ports:
clk  input  1  clock; all logic on posedge
rstn  input  1  asynchronous reset, active-high
req_valid  input  NUM_REQ  per-requester beat valid
req_data  input  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  per-requester beat accepted (combinational from state and flags)
o_full  input  1  FIFO full flag
o_alm_full  input  1  FIFO almost-full flag; FIFO threshold must leave at least 2 free entries
i_wren  output  1  FIFO write enable, registered
i_wrdata  output  DATA_W  FIFO write data, registered
grant_id  output  $clog2(NUM_REQ)  index of current or last granted requester
busy  output  1  high in BURST state

Behaviour:
- Reset (async, rstn=1): state=IDLE, i_wren=0, i_wrdata=0, req_ready=0, grant_id=NUM_REQ-1, beat_cnt=0, busy=0. Any registered write in flight is dropped.
- stall = o_full | o_alm_full.
- IDLE:
  - If any req_valid is high, select the first valid index scanning from grant_id+1 upward, with modulo NUM_REQ wrap.
  - Load grant_id with that index, clear beat_cnt, go to BURST.
  - req_ready stays all-zero in IDLE, so arbitration costs 1 cycle.
- BURST (g = grant_id):
  - req_ready[g] = ~stall. All other ready bits are 0.
  - Accept when req_valid[g] & req_ready[g]. On accept, the next cycle has i_wren=1 and i_wrdata=req_data[g]. Otherwise i_wren=0 next cycle. i_wrdata holds its last value when not writing.
  - On accept with beat_cnt==MAX_BURST-1: go to IDLE; otherwise beat_cnt++.
  - If req_valid[g]==0: go to IDLE with no write. grant_id is retained, so that requester has lowest priority next round.
  - Stall with valid held: stay in BURST. beat_cnt is frozen and the grant is not released.
- Latency: accepted beat to i_wren is exactly 1 cycle. Beat ordering per requester is preserved.
- Fairness: a continuously-valid requester waits at most (NUM_REQ-1)*(MAX_BURST+1) non-stalled cycles for a grant.
- Full boundary:
  - The 2-entry almost-full margin absorbs the one registered write in flight.
  - i_wren is never asserted in a cycle where o_full was high at the preceding edge and no read occurred. The bench checks this as an assertion against the FIFO model.
- Simultaneous events:
  - Valid drop and stall in the same cycle: the valid drop wins, go to IDLE.
  - A requester asserting valid during another's burst waits for the next IDLE.
- Single requester: alternates MAX_BURST beats and 1 idle cycle (throughput MAX_BURST/(MAX_BURST+1)).

Optional Feature:
FIFO_ARB_STATS_EN
- Defined: adds output stat_beats (NUM_REQ*32), one saturating 32-bit beat counter per requester.
  - Counter increments on each accepted beat and holds at 0xFFFFFFFF.
  - Adds input stat_clr (1 bit): synchronous clear of all counters. When clear and accept coincide, clear wins.
  - All counters reset to 0.
- Not defined: ports and counters are absent. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset mid-burst: assert rstn on cycle 3 of a req0 burst -> same cycle: i_wren=0, req_ready=0, grant_id=3; after release, the first grant goes to req0.
- Single requester: req1 valid held with data 0x1,0x2,... and no stall -> i_wren pattern 1,1,1,1,0 repeating, i_wrdata in order, grant_id=1.
- All four valid constantly -> grant order 0,1,2,3,0; each grant is exactly 4 beats; 1 idle cycle between grants.
- Stall: assert o_alm_full for 5 cycles during req2's second beat -> req_ready[2]=0 for 5 cycles, no i_wren, beat_cnt frozen; burst then completes with 4 total beats and no lost data.
- Early release: req3 drops valid after 2 beats while req0 is valid -> req3 gets 2 writes, then IDLE, then req0 is granted; req3 becomes lowest priority next round.
- FIFO_ARB_STATS_EN: 10 beats from req0 and 3 from req2 -> stat_beats[0]=10, stat_beats[2]=3, others 0; stat_clr -> all 0 next cycle.
